led_scan_driver: RTL and testbench
==================================

LED_SCAN_DRIVER -- requirements
Module: led_scan_driver

Interface
REQ-001 SHALL have parameter pLED_WIDTH, default 8, segment bits per digit (bit 7 = DP, bits 6:0 = g..a).
REQ-002 SHALL have parameter pLED_NO, default 2, number of digits scanned (digit 0 = units, digit 1 = dozens).
REQ-003 SHALL have parameter pSCAN_DIV, default 50, clock cycles each digit is lit (legal range >= 1).
REQ-004 SHALL have parameter pBLANK_CYCLES, default 2, anti-ghosting blank cycles after each digit (legal range >= 0).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-007 SHALL have port en, input, 1 bit, scan enable.
REQ-008 SHALL have port display_led, input, pLED_WIDTH*pLED_NO bits, packed segment codes {dozens, unit}; digit k occupies bits [k*pLED_WIDTH +: pLED_WIDTH].
REQ-009 SHALL have port seg, output, pLED_WIDTH bits, active-high segment drive.
REQ-010 SHALL have port digit_sel, output, pLED_NO bits, one-hot active-high digit enable.
REQ-011 SHALL have port frame_done, output, 1 bit, single-cycle end-of-frame strobe.

Function
REQ-012 SHALL implement the states IDLE, SHOW and BLANK, plus a digit index idx and a down-counter cnt; cnt width SHALL be clog2(max(pSCAN_DIV, pBLANK_CYCLES, 2)).
REQ-013 IDLE: seg=0, digit_sel=0; if en=1, the next edge SHALL latch snap<=display_led, set idx=0, cnt=pSCAN_DIV-1 and enter SHOW.
REQ-014 SHOW: seg SHALL equal snap digit idx and digit_sel SHALL be one-hot(idx).
REQ-015 SHOW: cnt SHALL decrement each cycle; at cnt=0 the block SHALL enter BLANK with cnt=pBLANK_CYCLES-1, or go straight to the next-digit step if pBLANK_CYCLES=0.
REQ-016 BLANK: seg=0 and digit_sel=0; cnt SHALL decrement; at cnt=0 the block SHALL take the next-digit step.
REQ-017 Next-digit step: if idx<pLED_NO-1, then idx+1, cnt=pSCAN_DIV-1 and SHOW; else idx=0, snap<=display_led (re-latch), cnt=pSCAN_DIV-1 and SHOW.
REQ-018 frame_done SHALL be 1 for exactly the last cycle of each completed frame (the cycle whose edge takes the wrap-around step) and 0 otherwise.
REQ-019 Frame period SHALL be exactly pLED_NO*(pSCAN_DIV+pBLANK_CYCLES) cycles.
REQ-020 Changes on display_led between frame boundaries SHALL NOT affect seg until the next re-latch.
REQ-021 en=0 sampled in any state SHALL force IDLE, seg=0, digit_sel=0 and frame_done=0 from the next cycle; an aborted frame SHALL NOT produce frame_done.
REQ-022 seg, digit_sel and frame_done SHALL be decoded only from registered state, with no combinational path from display_led or en.
REQ-023 digit_sel SHALL never have more than one bit set.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, idx=0, cnt=0 and snap=0; seg=0, digit_sel=0 and frame_done=0 until the first SHOW.
REQ-025 Reset SHALL have priority over en, including mid-frame; after rst deasserts with en=1, the first SHOW SHALL follow one cycle later.

Configuration
REQ-026 Macro LED_SCAN_LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-027 With LED_SCAN_LEADING_ZERO_BLANK_EN defined: in SHOW with idx=pLED_NO-1 and that snap digit equal to 8'h3F, seg=0 and digit_sel=0; timing is unchanged.
REQ-028 Without LED_SCAN_LEADING_ZERO_BLANK_EN: every digit SHALL be displayed as latched.

Verification (pSCAN_DIV=4, pBLANK_CYCLES=1, pLED_NO=2)
REQ-029 Stimulus rst then en=1 with display_led=16'h0666 -> SHOW idx0 for 4 cycles (seg=8'h66, digit_sel=01), 1 blank, then SHOW idx1 for 4 cycles (seg=8'h06, digit_sel=10), 1 blank, then frame_done=1 on cycle 10, and this repeats every 10 cycles.
REQ-030 Stimulus: change display_led to 16'h3F07 mid-frame -> current frame still shows 66/06, and the next frame shows 07/3F.
REQ-031 Stimulus: drop en during idx1 SHOW -> outputs are 0 next cycle and no frame_done; re-raise en -> restart at idx0 with a fresh latch.
REQ-032 Stimulus: assert rst mid-BLANK with en=1 -> IDLE next edge, all outputs 0; after release, SHOW idx0 starts after one cycle.
REQ-033 Stimulus: macro defined, display_led=16'h3F5B -> digit1 slot is blank (seg=0, digit_sel=0) for 4 cycles while digit0 shows 8'h5B; macro undefined -> digit1 shows 8'h3F.
REQ-034 Stimulus: pBLANK_CYCLES=0 build -> no zero-output cycles between digits and frame period is 8.

Source files
------------

// File: rtl/led_scan_driver.sv
// led_scan_driver
//
// Time-multiplexed driver for a row of 7-segment (+DP) digits. A snapshot of
// display_led is taken at the start of every frame. Each digit is then lit for
// pSCAN_DIV cycles, followed by pBLANK_CYCLES dark cycles that suppress
// ghosting while the digit enables switch over.
//
// Parameters
//   pLED_WIDTH    segment bits per digit (bit 7 = DP, bits 6:0 = g..a)
//   pLED_NO       number of digits scanned (digit 0 = units)
//   pSCAN_DIV     cycles each digit is lit (>= 1)
//   pBLANK_CYCLES dark cycles after each digit (>= 0)
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   en           scan enable; low returns the driver to IDLE
//   display_led  packed segment codes, digit k at [k*pLED_WIDTH +: pLED_WIDTH]
//   seg          active-high segment drive
//   digit_sel    one-hot active-high digit enable
//   frame_done   high during the last cycle of each completed frame
//
// Build option
//   LED_SCAN_LEADING_ZERO_BLANK_EN : when defined, the most significant digit
//   is kept dark while its latched code is 8'h3F ("0"). Timing is unchanged.
//
// All outputs are registers loaded from the next-state values, so there is no
// combinational path from en or display_led to any output.

module led_scan_driver #(
   parameter int pLED_WIDTH    = 8,
   parameter int pLED_NO       = 2,
   parameter int pSCAN_DIV     = 50,
   parameter int pBLANK_CYCLES = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic [pLED_WIDTH*pLED_NO-1:0]  display_led,
   output logic [pLED_WIDTH-1:0]          seg,
   output logic [pLED_NO-1:0]             digit_sel,
   output logic                           frame_done
);

   localparam int MAX_AB  = (pSCAN_DIV > pBLANK_CYCLES) ? pSCAN_DIV : pBLANK_CYCLES;
   localparam int CNT_MAX = (MAX_AB > 2) ? MAX_AB : 2;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int IDX_W   = (pLED_NO > 1) ? $clog2(pLED_NO) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(pLED_NO - 1);
   localparam logic [CNT_W-1:0] SCAN_LOAD  = CNT_W'(pSCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((pBLANK_CYCLES > 0) ? (pBLANK_CYCLES - 1) : 0);
   localparam logic [pLED_WIDTH-1:0] ZERO_CODE = pLED_WIDTH'(8'h3F);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } state_t;

   state_t                          state_reg,  state_next;
   logic [IDX_W-1:0]                idx_reg,    idx_next;
   logic [CNT_W-1:0]                cnt_reg,    cnt_next;
   logic [pLED_WIDTH*pLED_NO-1:0]   snap_reg,   snap_next;
   logic [pLED_WIDTH-1:0]           seg_reg,    seg_next;
   logic [pLED_NO-1:0]              digit_sel_reg, digit_sel_next;
   logic                            frame_done_reg, frame_done_next;

   logic                            advance;
   logic                            last_cycle_state;

   // Per-digit view of the snapshot that will be current next cycle, and the
   // matching one-hot enable pattern.
   logic [pLED_WIDTH-1:0]           digit_next [pLED_NO];
   logic [pLED_NO-1:0]              onehot_next;

   genvar gi;
   generate
      for (gi = 0; gi < pLED_NO; gi++) begin : g_digit
         assign digit_next[gi]  = snap_next[gi*pLED_WIDTH +: pLED_WIDTH];
         assign onehot_next[gi] = (idx_next == IDX_W'(gi));
      end
   endgenerate

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      snap_next  = snap_reg;
      advance    = 1'b0;

      if (!en) begin
         state_next = IDLE;
         idx_next   = '0;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               snap_next  = display_led;
               idx_next   = '0;
               cnt_next   = SCAN_LOAD;
               state_next = SHOW;
            end
            SHOW: begin
               if (cnt_reg == '0) begin
                  if (pBLANK_CYCLES > 0) begin
                     state_next = BLANK;
                     cnt_next   = BLANK_LOAD;
                  end else begin
                     advance = 1'b1;
                  end
               end else begin
                  cnt_next = cnt_reg - CNT_W'(1);
               end
            end
            BLANK: begin
               if (cnt_reg == '0) begin
                  advance = 1'b1;
               end else begin
                  cnt_next = cnt_reg - CNT_W'(1);
               end
            end
            default: begin
               state_next = IDLE;
               idx_next   = '0;
               cnt_next   = '0;
            end
         endcase

         // Move to the next digit; wrapping past the last digit starts a new
         // frame and refreshes the snapshot.
         if (advance) begin
            state_next = SHOW;
            cnt_next   = SCAN_LOAD;
            if (idx_reg != LAST_IDX) begin
               idx_next = idx_reg + IDX_W'(1);
            end else begin
               idx_next  = '0;
               snap_next = display_led;
            end
         end
      end
   end

   // Output values for the cycle that follows this edge
   always_comb begin
      seg_next       = '0;
      digit_sel_next = '0;

      if (state_next == SHOW) begin
         seg_next       = digit_next[idx_next];
         digit_sel_next = onehot_next;
`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
         if ((idx_next == LAST_IDX) && (digit_next[idx_next] == ZERO_CODE)) begin
            seg_next       = '0;
            digit_sel_next = '0;
         end
`endif
      end

      // The final cycle of a frame is the last dark cycle of the last digit,
      // or its last lit cycle when there are no dark cycles.
      if (pBLANK_CYCLES > 0) begin
         last_cycle_state = (state_next == BLANK);
      end else begin
         last_cycle_state = (state_next == SHOW);
      end
      frame_done_next = last_cycle_state && (cnt_next == '0) && (idx_next == LAST_IDX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         idx_reg        <= '0;
         cnt_reg        <= '0;
         snap_reg       <= '0;
         seg_reg        <= '0;
         digit_sel_reg  <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         cnt_reg        <= cnt_next;
         snap_reg       <= snap_next;
         seg_reg        <= seg_next;
         digit_sel_reg  <= digit_sel_next;
         frame_done_reg <= frame_done_next;
      end
   end

   assign seg        = seg_reg;
   assign digit_sel  = digit_sel_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_led_scan_driver.sv
// Bench for led_scan_driver: two instances (one dark cycle / no dark cycles)
// share the stimulus; a frame-position model predicts every output cycle.
module tb_led_scan_driver;
   localparam int W    = 8;
   localparam int NO   = 2;
   localparam int SCAN = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [15:0] display_led = 16'h0666;

   logic [7:0]  seg1, seg0;
   logic [1:0]  sel1, sel0;
   logic        fd1, fd0;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   // model state per instance: k=0 -> one dark cycle, k=1 -> none
   bit          m_act  [2];
   int          m_pos  [2];
   logic [15:0] m_snap [2];

   always #5 clk = ~clk;

   led_scan_driver #(.pLED_WIDTH(W), .pLED_NO(NO), .pSCAN_DIV(SCAN), .pBLANK_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .en(en), .display_led(display_led),
      .seg(seg1), .digit_sel(sel1), .frame_done(fd1));

   led_scan_driver #(.pLED_WIDTH(W), .pLED_NO(NO), .pSCAN_DIV(SCAN), .pBLANK_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .display_led(display_led),
      .seg(seg0), .digit_sel(sel0), .frame_done(fd0));

   function automatic int blank_of(input int k);
      return (k == 0) ? 1 : 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs from the position inside the frame
   task automatic model_out(input int blank, input bit act, input int pos, input logic [15:0] s,
                            output logic [7:0] e_seg, output logic [1:0] e_sel, output logic e_fd);
      int slot, period, d, w;
      logic [7:0] code;
      slot   = SCAN + blank;
      period = NO * slot;
      e_seg  = 8'h00;
      e_sel  = 2'b00;
      e_fd   = 1'b0;
      if (act) begin
         d = pos / slot;
         w = pos % slot;
         if (w < SCAN) begin
            code  = s[d*8 +: 8];
            e_seg = code;
            e_sel = 2'(1 << d);
`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
            if (d == NO - 1 && code == 8'h3F) begin
               e_seg = 8'h00;
               e_sel = 2'b00;
            end
`endif
         end
         e_fd = (pos == period - 1);
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_act[k]  <= 1'b0;
            m_snap[k] <= 16'h0;
         end else if (!en) begin
            m_act[k]  <= 1'b0;
         end else if (!m_act[k]) begin
            m_act[k]  <= 1'b1;
            m_pos[k]  <= 0;
            m_snap[k] <= display_led;
         end else if (m_pos[k] == NO * (SCAN + blank_of(k)) - 1) begin
            m_pos[k]  <= 0;
            m_snap[k] <= display_led;
         end else begin
            m_pos[k]  <= m_pos[k] + 1;
         end
      end
   end

   // Cycle-by-cycle compare against the model
   always @(negedge clk) begin
      logic [7:0] es;
      logic [1:0] el;
      logic       ef;
      if (chk_on) begin
         model_out(1, m_act[0], m_pos[0], m_snap[0], es, el, ef);
         check("seg_b1", 32'(seg1), 32'(es));
         check("sel_b1", 32'(sel1), 32'(el));
         check("fd_b1",  32'(fd1),  32'(ef));
         check("onehot_b1", 32'($countones(sel1) <= 1), 32'd1);
         model_out(0, m_act[1], m_pos[1], m_snap[1], es, el, ef);
         check("seg_b0", 32'(seg0), 32'(es));
         check("sel_b0", 32'(sel0), 32'(el));
         check("fd_b0",  32'(fd0),  32'(ef));
         check("onehot_b0", 32'($countones(sel0) <= 1), 32'd1);
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      check("rst_seg", 32'(seg1), 32'h0);
      check("rst_sel", 32'(sel1), 32'h0);
      check("rst_fd",  32'(fd1),  32'h0);
      $display("reset released, en=1, display_led=%h", display_led);
      rst = 1'b0;
      en  = 1'b1;

      // frame 1: 0666
      @(negedge clk);     check("c1_seg", 32'(seg1), 32'h66); check("c1_sel", 32'(sel1), 32'h1);
                          check("c1_seg0", 32'(seg0), 32'h66);
      repeat (3) @(negedge clk); check("c4_seg", 32'(seg1), 32'h66); check("c4_seg0", 32'(seg0), 32'h66);
      @(negedge clk);     check("c5_blank_seg", 32'(seg1), 32'h0); check("c5_blank_sel", 32'(sel1), 32'h0);
                          check("c5_seg0", 32'(seg0), 32'h06); check("c5_sel0", 32'(sel0), 32'h2);
      @(negedge clk);     check("c6_seg", 32'(seg1), 32'h06); check("c6_sel", 32'(sel1), 32'h2);
      repeat (2) @(negedge clk); check("c8_fd0", 32'(fd0), 32'h1); check("c8_fd", 32'(fd1), 32'h0);
      repeat (2) @(negedge clk); check("c10_fd", 32'(fd1), 32'h1); check("c10_seg", 32'(seg1), 32'h0);
      @(negedge clk);     check("c11_seg", 32'(seg1), 32'h66); check("c11_fd", 32'(fd1), 32'h0);
      $display("frame 1 done, display_led -> 3f07 mid-frame");

      display_led = 16'h3F07;
      repeat (5) @(negedge clk); check("old_snap_seg", 32'(seg1), 32'h06);
      repeat (5) @(negedge clk); check("new_snap_seg", 32'(seg1), 32'h07); check("new_snap_sel", 32'(sel1), 32'h1);
      repeat (5) @(negedge clk);
`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
      check("lz_seg", 32'(seg1), 32'h0); check("lz_sel", 32'(sel1), 32'h0);
`else
      check("d1_seg", 32'(seg1), 32'h3F); check("d1_sel", 32'(sel1), 32'h2);
`endif
      $display("en dropped during digit 1");
      en = 1'b0;
      @(negedge clk);     check("off_seg", 32'(seg1), 32'h0); check("off_sel", 32'(sel1), 32'h0);
                          check("off_fd", 32'(fd1), 32'h0); check("off_seg0", 32'(seg0), 32'h0);
      repeat (3) @(negedge clk);

      display_led = 16'h3F5B;
      en = 1'b1;
      $display("en raised, display_led=%h", display_led);
      @(negedge clk);     check("re_seg", 32'(seg1), 32'h5B); check("re_sel", 32'(sel1), 32'h1);
      repeat (5) @(negedge clk);
`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
      check("lz2_seg", 32'(seg1), 32'h0); check("lz2_sel", 32'(sel1), 32'h0);
`else
      check("d1b_seg", 32'(seg1), 32'h3F); check("d1b_sel", 32'(sel1), 32'h2);
`endif
      repeat (4) @(negedge clk); check("re_fd", 32'(fd1), 32'h1);
      repeat (5) @(negedge clk); check("mid_blank_seg", 32'(seg1), 32'h0); check("mid_blank_sel", 32'(sel1), 32'h0);
      $display("rst asserted mid-blank with en=1");
      rst = 1'b1;
      @(negedge clk);     check("rst_mid_seg", 32'(seg1), 32'h0); check("rst_mid_seg0", 32'(seg0), 32'h0);
                          check("rst_mid_fd0", 32'(fd0), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);     check("post_rst_seg", 32'(seg1), 32'h5B); check("post_rst_sel", 32'(sel1), 32'h1);
                          check("post_rst_seg0", 32'(seg0), 32'h5B);
      $display("reset released, scanning resumed");
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
